int8_to_int32_decompressor: RTL and testbench
=============================================

INT8_TO_INT32_DECOMPRESSOR -- requirements
Module: int8_to_int32_decompressor

Interface
REQ-001 SHALL have parameter: LANES, 4, number of int8 values per packed input word; legal values 1, 2, 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  packed word and scale valid.
REQ-005 SHALL have port: in_ready  output  1  block accepts a packed word this cycle.
REQ-006 SHALL have port: in_w  input  8*LANES  packed signed int8 values; lane k = bits [8k+7:8k].
REQ-007 SHALL have port: scale  input  32  one-hot power-of-two scale, same encoding as the compressor.
REQ-008 SHALL have port: out_valid  output  1  out_w holds a dequantized value.
REQ-009 SHALL have port: out_ready  input  1  downstream consumes out_w this cycle.
REQ-010 SHALL have port: out_w  output  32  signed int32 dequantized lane value.
REQ-011 SHALL have port: out_last  output  1  out_w is the final lane of the current word.
REQ-012 SHALL have port: sat_flag  output  1  sticky; an output value was clamped.

Function
REQ-013 SHALL decode shift sh (0-31) from scale as the index of the highest set bit; scale==0 gives sh=0.
REQ-014 SHALL capture in_w and sh on the edge where in_valid && in_ready; scale is not sampled at any other time.
REQ-015 SHALL implement states IDLE (no word buffered) and UNPACK (word buffered, lane counter 0..LANES-1).
REQ-016 SHALL drive in_ready=1 in IDLE, and in UNPACK only when out_valid && out_ready && lane counter==LANES-1; otherwise 0.
REQ-017 SHALL present lane 0 on out_w with out_valid=1 on the cycle following acceptance (latency 1 cycle), then lanes 1..LANES-1 in order.
REQ-018 SHALL advance the lane counter only on out_valid && out_ready; out_w, out_last and out_valid SHALL be held stable while out_valid && !out_ready.
REQ-019 SHALL assert out_last with the lane LANES-1 value only.
REQ-020 SHALL, on consumption of the last lane with in_valid=1, accept the new word on the same edge and present its lane 0 next cycle (no bubble; one value per cycle sustained).
REQ-021 SHALL, on consumption of the last lane with in_valid=0, return to IDLE and drive out_valid=0 next cycle.
REQ-022 SHALL compute out_w = sign-extended lane value multiplied by 2^sh, evaluated at least 40 bits wide before range handling.
REQ-023 SHALL ignore in_w and scale whenever in_ready=0.

Reset
REQ-024 SHALL, while rst=1, force out_valid=0, out_last=0, out_w=0, sat_flag=0, in_ready=0, state IDLE, lane counter 0.
REQ-025 SHALL, on rst mid-UNPACK, discard the buffered word without emitting remaining lanes; in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with DECOMP_SATURATE_EN defined, clamp results above 2147483647 to 2147483647 and below -2147483648 to -2147483648, setting sat_flag=1 on the edge the clamped value is first presented; sat_flag stays 1 until reset.
REQ-027 SHALL, without DECOMP_SATURATE_EN, output the low 32 bits of the product (wrap) and tie sat_flag to 0.

Verification
REQ-028 SHALL cover: LANES=4, in_w=0x80_7F_FF_01, scale=0x10 (sh=4), out_ready=1 -> out_w 16, -16, 2032, -2048 on four consecutive cycles, out_last on the fourth.
REQ-029 SHALL cover: lane 127, scale=1<<25 -> with macro out_w=2147483647, sat_flag=1; without macro out_w=-33554432, sat_flag=0.
REQ-030 SHALL cover: lane -128, scale=1<<24 -> out_w=-2147483648, sat_flag stays 0 in both builds.
REQ-031 SHALL cover: out_ready held 0 for 3 cycles during lane 1 -> out_w, out_last constant, in_ready=0, no lane skipped after release.
REQ-032 SHALL cover: back-to-back words with in_valid=1 continuously -> 8 values on 8 consecutive cycles, in_ready=1 only on each word's last-lane handshake cycle.
REQ-033 SHALL cover: rst asserted after lane 1 of a word -> out_valid=0 immediately, next accepted word starts at lane 0; scale=0x0000_0006 decodes sh=2.

Source files
------------

// File: rtl/int8_to_int32_decompressor.sv
// int8_to_int32_decompressor
//
// Takes a word of LANES packed signed int8 values together with a one-hot
// power-of-two scale. It returns them one lane per cycle as signed int32
// values equal to lane * 2^sh, where sh is the index of the highest set bit
// of scale. Lane 0 appears on the cycle after the word is accepted. The next
// word can be accepted on the same edge that the last lane is consumed, so a
// continuous input stream produces one value per cycle with no gaps.
//
// Build option:
//   DECOMP_SATURATE_EN  defined   : results are clamped to the int32 range,
//                                   and sat_flag latches high until reset.
//                       undefined : results wrap to the low 32 bits, and
//                                   sat_flag is tied to 0.
//
// Ports:
//   clk        in   clock; all state changes on the rising edge
//   rst        in   asynchronous reset, active high
//   in_valid   in   in_w and scale are valid
//   in_ready   out  a packed word is accepted this cycle
//   in_w       in   packed signed int8 lanes; lane k = in_w[8k+7:8k]
//   scale      in   one-hot power-of-two scale
//   out_valid  out  out_w holds a dequantized lane
//   out_ready  in   downstream consumes out_w this cycle
//   out_w      out  signed int32 dequantized lane value
//   out_last   out  out_w is the last lane of the current word
//   sat_flag   out  sticky; some output value was clamped

module int8_to_int32_decompressor #(
   parameter int unsigned LANES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [8*LANES-1:0]   in_w,
   input  logic [31:0]          scale,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_w,
   output logic                 out_last,
   output logic                 sat_flag
);

   localparam int unsigned      LaneW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);

   typedef enum logic [0:0] {StIdle, StUnpack} state_e;

   state_e               state_q, state_d;
   logic [LaneW-1:0]     lane_q, lane_d;
   logic [8*LANES-1:0]   word_q, word_d;
   logic [4:0]           sh_q, sh_d;
   logic [31:0]          out_w_q, out_w_d;
   logic                 out_last_q, out_last_d;

   logic [4:0]           sh_dec;
   logic                 last_lane, accept, consume;
   logic [8*LANES-1:0]   sel_word;
   logic [4:0]           sel_sh;
   logic [LaneW-1:0]     sel_lane;
   logic [7:0]           lane_val;
   logic signed [39:0]   prod;
   logic [31:0]          res;

`ifdef DECOMP_SATURATE_EN
   localparam logic signed [39:0] MaxV = 40'sh00_7FFF_FFFF;
   localparam logic signed [39:0] MinV = 40'shFF_8000_0000;
   logic clamp;
   logic sat_q, sat_d;
`endif

   // Highest set bit wins, so a malformed multi-hot scale still decodes sanely.
   always_comb begin
      sh_dec = '0;
      for (int i = 0; i < 32; i++) begin
         if (scale[i]) sh_dec = 5'(i);
      end
   end

   assign out_valid = (state_q == StUnpack);
   assign last_lane = (lane_q == LastLane);
   assign in_ready  = !rst && (!out_valid || (out_ready && last_lane));
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;
   assign out_w     = out_w_q;
   assign out_last  = out_last_q;

   // Pick the lane to be presented after this edge: lane 0 of the incoming
   // word on accept, otherwise the next lane of the buffered word.
   always_comb begin
      sel_word = accept ? in_w : word_q;
      sel_sh   = accept ? sh_dec : sh_q;
      sel_lane = accept ? '0 : lane_q + 1'b1;
      lane_val = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         if (sel_lane == LaneW'(k)) lane_val = sel_word[8*k +: 8];
      end
      // 40 bits holds -128 * 2^31 and 127 * 2^31 exactly.
      prod = {{32{lane_val[7]}}, lane_val} << sel_sh;
`ifdef DECOMP_SATURATE_EN
      clamp = 1'b0;
      if (prod > MaxV) begin
         res   = 32'h7FFF_FFFF;
         clamp = 1'b1;
      end else if (prod < MinV) begin
         res   = 32'h8000_0000;
         clamp = 1'b1;
      end else begin
         res = prod[31:0];
      end
`else
      res = prod[31:0];
`endif
   end

   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      word_d     = word_q;
      sh_d       = sh_q;
      out_w_d    = out_w_q;
      out_last_d = out_last_q;
`ifdef DECOMP_SATURATE_EN
      sat_d      = sat_q;
`endif
      if (accept) begin
         state_d    = StUnpack;
         lane_d     = '0;
         word_d     = in_w;
         sh_d       = sh_dec;
         out_w_d    = res;
         out_last_d = (sel_lane == LastLane);
`ifdef DECOMP_SATURATE_EN
         sat_d      = sat_q | clamp;
`endif
      end else if (consume) begin
         if (last_lane) begin
            state_d    = StIdle;
            lane_d     = '0;
            out_w_d    = '0;
            out_last_d = 1'b0;
         end else begin
            lane_d     = sel_lane;
            out_w_d    = res;
            out_last_d = (sel_lane == LastLane);
`ifdef DECOMP_SATURATE_EN
            sat_d      = sat_q | clamp;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         lane_q     <= '0;
         word_q     <= '0;
         sh_q       <= '0;
         out_w_q    <= '0;
         out_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         word_q     <= word_d;
         sh_q       <= sh_d;
         out_w_q    <= out_w_d;
         out_last_q <= out_last_d;
      end
   end

`ifdef DECOMP_SATURATE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sat_q <= 1'b0;
      else     sat_q <= sat_d;
   end
   assign sat_flag = sat_q;
`else
   assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_int8_to_int32_decompressor.sv
// Directed testbench for int8_to_int32_decompressor (LANES = 4).
// Expected values are computed by hand from lane * 2^sh.

module tb_int8_to_int32_decompressor;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_w;
   logic [31:0] scale;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_w;
   logic        out_last;
   logic        sat_flag;

   int n_checks = 0;
   int n_fail   = 0;

   int8_to_int32_decompressor #(
      .LANES(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_w      (in_w),
      .scale     (scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_w     (out_w),
      .out_last  (out_last),
      .sat_flag  (sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_lane(input string tag, input logic [31:0] w, input logic last);
      check({tag, "/valid"}, 32'(out_valid), 32'd1);
      check({tag, "/w"}, out_w, w);
      check({tag, "/last"}, 32'(out_last), 32'(last));
   endtask

   // Present one word for one cycle; it is accepted on that edge.
   task automatic send(input logic [31:0] w, input logic [31:0] sc);
      in_valid = 1'b1;
      in_w     = w;
      scale    = sc;
      step();
      in_valid = 1'b0;
   endtask

   // Drain four lanes with out_ready=1 and check the return to idle.
   task automatic expect_word(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] e [4];
      e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
      for (int i = 0; i < 4; i++) begin
         expect_lane($sformatf("%s_l%0d", tag, i), e[i], i == 3);
         check($sformatf("%s_rdy%0d", tag, i), 32'(in_ready), (i == 3) ? 32'd1 : 32'd0);
         step();
      end
      check({tag, "_idle"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_w      = '0;
      scale     = '0;
      out_ready = 1'b1;
      repeat (2) step();

      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_last", 32'(out_last), 32'd0);
      check("rst_w", out_w, 32'd0);
      check("rst_sat", 32'(sat_flag), 32'd0);
      check("rst_rdy", 32'(in_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_rdy", 32'(in_ready), 32'd1);

      // Mixed-sign lanes, sh=4.
      send(32'h807F_FF01, 32'h10);
      expect_word("basic", 32'd16, 32'hFFFF_FFF0, 32'd2032, 32'hFFFF_F800);

      // Stall on lane 1; garbage on the input must be ignored.
      send(32'h0403_0201, 32'h1);
      expect_lane("st_l0", 32'd1, 1'b0);
      step();
      expect_lane("st_l1", 32'd2, 1'b0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_w      = 32'hAAAA_AAAA;
      scale     = 32'h100;
      #1;
      check("st_rdy", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_lane($sformatf("st_hold%0d", i), 32'd2, 1'b0);
         check($sformatf("st_hold_rdy%0d", i), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1;
      expect_lane("st_rel1", 32'd2, 1'b0);
      step();
      expect_lane("st_rel2", 32'd3, 1'b0);
      step();
      expect_lane("st_rel3", 32'd4, 1'b1);
      step();
      check("st_idle", 32'(out_valid), 32'd0);

      // Back-to-back words with in_valid held high.
      in_valid = 1'b1;
      in_w     = 32'h0403_0201;
      scale    = 32'h1;
      step();
      in_w  = 32'h0807_0605;
      scale = 32'h2;
      for (int i = 0; i < 8; i++) begin
         expect_lane($sformatf("b2b_%0d", i),
                     (i < 4) ? 32'(i + 1) : 32'(2 * (i + 1)), (i % 4) == 3);
         check($sformatf("b2b_rdy%0d", i), 32'(in_ready), ((i % 4) == 3) ? 32'd1 : 32'd0);
         step();
         if (i == 3) in_valid = 1'b0;
      end
      check("b2b_idle", 32'(out_valid), 32'd0);

      // Reset in the middle of a word; scale 0x6 decodes sh=2.
      send(32'h4433_2211, 32'h6);
      expect_lane("mr_l0", 32'd68, 1'b0);
      step();
      expect_lane("mr_l1", 32'd136, 1'b0);
      rst = 1'b1;
      #1;
      check("mr_valid", 32'(out_valid), 32'd0);
      check("mr_w", out_w, 32'd0);
      check("mr_last", 32'(out_last), 32'd0);
      check("mr_rdy", 32'(in_ready), 32'd0);
      step();
      rst = 1'b0;
      #1;
      check("mr_rdy_after", 32'(in_ready), 32'd1);
      check("mr_valid_after", 32'(out_valid), 32'd0);
      send(32'h0000_0005, 32'h6);
      expect_word("mr_new", 32'd20, 32'd0, 32'd0, 32'd0);

      // scale == 0 decodes sh=0.
      send(32'hFD00_0005, 32'h0);
      expect_word("sc0", 32'd5, 32'd0, 32'd0, 32'hFFFF_FFFD);

      // -128 * 2^24 is exactly INT32_MIN: no clamp in either build.
      send(32'h0000_0080, 32'h0100_0000);
      check("min_sat0", 32'(sat_flag), 32'd0);
      expect_word("min", 32'h8000_0000, 32'd0, 32'd0, 32'd0);
      check("min_sat1", 32'(sat_flag), 32'd0);

      // 127 * 2^25 overflows int32.
      send(32'h0000_007F, 32'h0200_0000);
`ifdef DECOMP_SATURATE_EN
      check("ovf_sat0", 32'(sat_flag), 32'd1);
      expect_word("ovf", 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0);
      check("ovf_sat1", 32'(sat_flag), 32'd1);
`else
      check("ovf_sat0", 32'(sat_flag), 32'd0);
      expect_word("ovf", 32'hFE00_0000, 32'd0, 32'd0, 32'd0);
      check("ovf_sat1", 32'(sat_flag), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
